// File: rtl/team_02_pkg.sv
// team_02 Wishbone master engine shared types and constants.
// Imported by the engine top and its read FIFO.
package team_02_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_FINISH
    } wbm_state_e;

    localparam logic [3:0]  WB_SEL_ALL   = 4'hF;
    localparam logic [31:0] WB_ADDR_STEP = 32'd4;

endpackage

// File: rtl/team_02_wbm_fifo.sv
// Read-data FIFO for the team_02 Wishbone master engine.
// Power-of-2 depth, pointers wrap naturally, occupancy exported.
module team_02_wbm_fifo
    import team_02_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [31:0]            data_i,
    input  logic                   pop_i,
    output logic [31:0]            data_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    // Pointer and occupancy tracking; push+pop together keeps count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop_i) begin
                rd_q <= rd_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/team_02_wbm_engine.sv
// team_02 Wishbone classic master engine: single-beat cycles with
// incrementing address, read data to a FIFO, write data from a stream.
module team_02_wbm_engine
    import team_02_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [7:0]  req_len,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] ADR_O,
    output logic [31:0] DAT_O,
    output logic [3:0]  SEL_O,
    output logic        WE_O,
    output logic        STB_O,
    output logic        CYC_O,
    input  logic        ACK_I,
    input  logic [31:0] DAT_I
);

    localparam int         CW       = $clog2(DEPTH) + 1;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    wbm_state_e  state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [7:0]  beats_q, beats_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        we_q, we_d;
    logic        mid_q, mid_d;
    logic        err_q, err_d;

    logic [CW-1:0] fifo_cnt;
    logic          has_space;
    logic          beat_ack;
    logic          push;
    logic          pop;

    assign has_space = fifo_cnt < CW'(DEPTH);
    assign STB_O     = (state_q == ST_ISSUE) && (we_q || has_space);
    assign CYC_O     = (state_q == ST_ISSUE) ||
                       ((state_q == ST_FETCH) && mid_q);
    assign beat_ack  = STB_O & ACK_I;
    assign push      = beat_ack & ~we_q;
    assign pop       = rd_valid & rd_ready;
    assign rd_valid  = fifo_cnt != '0;

    assign req_ready = state_q == ST_IDLE;
    assign busy      = state_q != ST_IDLE;
    assign wr_ready  = state_q == ST_FETCH;
    assign done      = (state_q == ST_FINISH) && !err_q;
    assign err       = (state_q == ST_FINISH) && err_q;
    assign ADR_O     = adr_q;
    assign DAT_O     = dat_q;
    assign SEL_O     = WB_SEL_ALL;
    assign WE_O      = we_q && (state_q != ST_IDLE);

    team_02_wbm_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (DAT_I),
        .pop_i   (pop),
        .data_o  (rd_data),
        .count_o (fifo_cnt)
    );

    // Transfer sequencing: accept, fetch write word, issue beat, finish.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        beats_d = beats_q;
        tmo_d   = tmo_q;
        we_d    = we_q;
        mid_d   = mid_q;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    adr_d   = req_addr & ~32'h3;
                    we_d    = req_we;
                    beats_d = req_len;
                    mid_d   = 1'b0;
                    tmo_d   = '0;
                    if (req_len == 8'd0) begin
                        state_d = ST_FINISH;
                    end else if (req_we) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_FETCH: begin
                if (wr_valid) begin
                    dat_d   = wr_data;
                    tmo_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (beat_ack) begin
                    adr_d   = adr_q + WB_ADDR_STEP;
                    beats_d = beats_q - 8'd1;
                    tmo_d   = '0;
                    mid_d   = 1'b1;
                    if (beats_q == 8'd1) begin
                        state_d = ST_FINISH;
                    end else if (we_q) begin
                        state_d = ST_FETCH;
                    end
                end else if (STB_O) begin
                    if (tmo_q == TMO_LAST) begin
                        state_d = ST_FINISH;
                        err_d   = 1'b1;
                    end else begin
                        tmo_d = tmo_q + 8'd1;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            beats_q <= '0;
            tmo_q   <= '0;
            we_q    <= 1'b0;
            mid_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            beats_q <= beats_d;
            tmo_q   <= tmo_d;
            we_q    <= we_d;
            mid_q   <= mid_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_team_02_wbm_engine.sv
// Bench for team_02_wbm_engine: random transfers against a
// transaction-level model of the slave, producer and consumer.
module tb_team_02_wbm_engine;

    localparam int DEPTH = 4;
    localparam int TMO   = 10;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] ADR_O;
    logic [31:0] DAT_O;
    logic [3:0]  SEL_O;
    logic        WE_O;
    logic        STB_O;
    logic        CYC_O;
    logic        ACK_I;
    logic [31:0] DAT_I;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    team_02_wbm_engine #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TMO)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .ADR_O     (ADR_O),
        .DAT_O     (DAT_O),
        .SEL_O     (SEL_O),
        .WE_O      (WE_O),
        .STB_O     (STB_O),
        .CYC_O     (CYC_O),
        .ACK_I     (ACK_I),
        .DAT_I     (DAT_I)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transfer; maxwait=0 means zero-wait slave, always-valid
    // producer and always-ready consumer (unless stall holds reads).
    task automatic run_xfer(input bit we, input logic [31:0] addr,
                            input int len, input int maxwait,
                            input bit stall);
        logic [31:0] wr_words[$];
        logic [31:0] base;
        int          beat;
        int          wr_idx;
        int          wait_n;
        int          qs;
        bit          last_prev;
        bit          fin;
        bit          exp_done;
        base = addr & ~32'h3;
        for (int i = 0; i < len; i++) wr_words.push_back($urandom);
        @(negedge clk_i);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_len   = 8'(len);
        ACK_I     = 1'b0;
        wr_valid  = 1'b0;
        beat      = 0;
        wr_idx    = 0;
        wait_n    = (maxwait == 0) ? 0 : $urandom_range(maxwait, 0);
        last_prev = 1'b0;
        fin       = 1'b0;
        for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
            @(negedge clk_i);
            req_valid = 1'b0;
            qs = exp_q.size();
            chk("rd_valid", {31'd0, rd_valid}, {31'd0, qs != 0});
            exp_done = (len == 0) ? (cyc == 1) : last_prev;
            last_prev = 1'b0;
            chk("done", {31'd0, done}, {31'd0, exp_done});
            if (exp_done) begin
                chk("err_at_done", {31'd0, err}, 32'd0);
                chk("busy_at_done", {31'd0, busy}, 32'd1);
                chk("cyc_at_done", {31'd0, CYC_O}, 32'd0);
                chk("rdy_at_done", {31'd0, req_ready}, 32'd0);
                if (maxwait == 0 && !stall)
                    chk("latency", cyc, we ? 2 * len + 1 : len + 1);
                fin = 1'b1;
            end
            ACK_I = 1'b0;
            DAT_I = $urandom;
            if (!fin && beat < len) begin
                if (!we) begin
                    chk("stb_space", {31'd0, STB_O},
                        {31'd0, qs < DEPTH});
                    chk("cyc_read", {31'd0, CYC_O}, 32'd1);
                end else if (beat > 0) begin
                    chk("cyc_held", {31'd0, CYC_O}, 32'd1);
                end
            end
            if (STB_O && !fin && beat < len) begin
                if (wait_n == 0) begin
                    ACK_I = 1'b1;
                    chk("adr", ADR_O, base + 32'(4 * beat));
                    chk("we", {31'd0, WE_O}, {31'd0, we});
                    chk("sel", {28'd0, SEL_O}, 32'hF);
                    if (we) chk("dat_o", DAT_O, wr_words[beat]);
                    else exp_q.push_back(DAT_I);
                    beat++;
                    if (beat == len) last_prev = 1'b1;
                    wait_n = (maxwait == 0) ? 0
                           : $urandom_range(maxwait, 0);
                end else begin
                    wait_n--;
                end
            end else if (STB_O) begin
                chk("stb_extra", {31'd0, STB_O}, 32'd0);
            end else begin
                ACK_I = 1'($urandom);
            end
            wr_valid = we && wr_idx < len &&
                       (maxwait == 0 || 1'($urandom));
            wr_data  = (wr_idx < len) ? wr_words[wr_idx] : $urandom;
            if (wr_valid && wr_ready) wr_idx++;
            if (stall) rd_ready = cyc > 12;
            else rd_ready = (maxwait == 0) ? 1'b1 : 1'($urandom);
            if (rd_valid && rd_ready)
                chk("rd_data", rd_data, exp_q.pop_front());
        end
        chk("done_seen", {31'd0, fin}, 32'd1);
        chk("beats", beat, len);
        for (int k = 0; k < DEPTH + 2 && exp_q.size() != 0; k++) begin
            @(negedge clk_i);
            ACK_I    = 1'b0;
            wr_valid = 1'b0;
            rd_ready = 1'b1;
            chk("drain_valid", {31'd0, rd_valid}, 32'd1);
            if (rd_valid) chk("drain_data", rd_data, exp_q.pop_front());
        end
        exp_q.delete();
    endtask

    task automatic run_timeout();
        @(negedge clk_i);
        chk("tmo_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = $urandom;
        req_len   = 8'd3;
        ACK_I     = 1'b0;
        rd_ready  = 1'b1;
        for (int k = 1; k <= TMO + 1; k++) begin
            @(negedge clk_i);
            req_valid = 1'b0;
            if (k == 1) chk("tmo_stb_rise", {31'd0, STB_O}, 32'd1);
            if (k == TMO) begin
                chk("tmo_stb_last", {31'd0, STB_O}, 32'd1);
                chk("tmo_no_err", {31'd0, err}, 32'd0);
            end
            if (k == TMO + 1) begin
                chk("tmo_err", {31'd0, err}, 32'd1);
                chk("tmo_done", {31'd0, done}, 32'd0);
                chk("tmo_cyc", {31'd0, CYC_O}, 32'd0);
                chk("tmo_busy", {31'd0, busy}, 32'd1);
            end
        end
        @(negedge clk_i);
        chk("tmo_ready", {31'd0, req_ready}, 32'd1);
        chk("tmo_err_pulse", {31'd0, err}, 32'd0);
    endtask

    task automatic run_reset_mid();
        @(negedge clk_i);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_1000;
        req_len   = 8'd5;
        rd_ready  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            req_valid = 1'b0;
            ACK_I     = 1'b1;
            DAT_I     = $urandom;
        end
        @(negedge clk_i);
        ACK_I = 1'b0;
        chk("rst_pre_valid", {31'd0, rd_valid}, 32'd1);
        chk("rst_pre_cyc", {31'd0, CYC_O}, 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("rst_cyc", {31'd0, CYC_O}, 32'd0);
        chk("rst_stb", {31'd0, STB_O}, 32'd0);
        chk("rst_fifo", {31'd0, rd_valid}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_adr", ADR_O, 32'd0);
        @(negedge clk_i);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_done2", {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst_i     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        ACK_I     = 1'b0;
        DAT_I     = '0;
        repeat (3) @(negedge clk_i);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done_v", {31'd0, done}, 32'd0);
        chk("rst_err_v", {31'd0, err}, 32'd0);
        chk("rst_stb_v", {31'd0, STB_O}, 32'd0);
        chk("rst_cyc_v", {31'd0, CYC_O}, 32'd0);
        chk("rst_we_v", {31'd0, WE_O}, 32'd0);
        chk("rst_rdv", {31'd0, rd_valid}, 32'd0);
        chk("rst_wrr", {31'd0, wr_ready}, 32'd0);
        chk("rst_adr_v", ADR_O, 32'd0);
        chk("rst_dat_v", DAT_O, 32'd0);
        chk("rst_sel_v", {28'd0, SEL_O}, 32'hF);
        rst_i = 1'b0;

        run_xfer(1'b0, 32'h3000_0000, 3, 0, 1'b0);
        run_xfer(1'b1, 32'h3000_0100, 2, 3, 1'b0);
        run_xfer(1'b1, 32'h2000_0000, 4, 0, 1'b0);
        run_xfer(1'b0, 32'h1234_5678, 0, 0, 1'b0);
        run_xfer(1'b1, 32'h1234_5678, 0, 0, 1'b0);
        run_xfer(1'b0, 32'h4000_0040, 6, 0, 1'b1);
        run_xfer(1'b1, 32'hFFFF_FFFB, 3, 0, 1'b0);
        run_xfer(1'b0, 32'hFFFF_FFF4, 4, 2, 1'b0);
        run_timeout();
        run_reset_mid();
        for (int t = 0; t < 30; t++) begin
            run_xfer(1'($urandom), $urandom, $urandom_range(9, 0),
                     $urandom_range(4, 0), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
